// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the IDFT frame sequencer: state encoding and beat geometry.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ARM    = 2'd2,
    STREAM = 2'd3
  } seq_state_e;

  localparam int IDFT_BEAT_W       = 64;
  localparam int IDFT_FRAME_CYCLES = 32;

endpackage

// File: rtl/idft_seq_buffer.sv
// One-frame store between the input stream and the IDFT core, with wrapping write and read pointers.
module idft_seq_buffer
  import dsp_seq_pkg::*;
#(
  parameter int FRAME_CYCLES = IDFT_FRAME_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [IDFT_BEAT_W-1:0] wr_data_i,
  input  logic                   rd_en_i,
  output logic [IDFT_BEAT_W-1:0] rd_data_o,
  output logic                   wr_last_o,
  output logic                   rd_last_o
);

  localparam int AW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [AW-1:0] LAST = AW'(FRAME_CYCLES - 1);

  logic [IDFT_BEAT_W-1:0] mem_q [FRAME_CYCLES];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign wr_last_o = (wr_ptr_q == LAST);
  assign rd_last_o = (rd_ptr_q == LAST);

endmodule

// File: rtl/idft_frame_sequencer.sv
// Frame-level controller for the IDFT core: buffers a frame, pulses next, streams it gap-free and frames the output.
// Optional next-to-next_out watchdog enabled by defining IDFT_SEQ_WATCHDOG_EN.
module idft_frame_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int FRAME_CYCLES   = IDFT_FRAME_CYCLES,
  parameter int MAX_INFLIGHT   = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   key_complete,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDFT_BEAT_W-1:0] in_data,
  output logic                   idft_next,
  output logic [IDFT_BEAT_W-1:0] idft_x,
  input  logic                   idft_next_out,
  input  logic [IDFT_BEAT_W-1:0] idft_y,
  output logic                   out_valid,
  output logic [IDFT_BEAT_W-1:0] out_data,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   busy,
  output logic [31:0]            frames_started,
  output logic [31:0]            frames_done,
  output logic                   err_timeout
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_FILL   = 2'(FILL);
  localparam logic [1:0] S_ARM    = 2'(ARM);
  localparam logic [1:0] S_STREAM = 2'(STREAM);

  localparam int IFW = $clog2(MAX_INFLIGHT + 1);
  localparam int OCW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [IFW-1:0] IF_MAX  = IFW'(MAX_INFLIGHT);
  localparam logic [OCW-1:0] OC_LAST = OCW'(FRAME_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic                   next_q, next_d;
  logic [IDFT_BEAT_W-1:0] x_q, x_d;
  logic [IFW-1:0]         inflight_q, inflight_d;
  logic [31:0]            started_q, started_d;
  logic [31:0]            done_q, done_d;
  logic                   act_q, act_d;
  logic [OCW-1:0]         ocnt_q, ocnt_d;
  logic                   ovld_q, ovld_d;
  logic                   sof_q, sof_d;
  logic                   eof_q, eof_d;
  logic [IDFT_BEAT_W-1:0] odata_q, odata_d;

  logic                   go, start_ok, eof_set, wd_fire;
  logic                   buf_wr, buf_rd, buf_wr_last, buf_rd_last;
  logic [IDFT_BEAT_W-1:0] buf_rd_data;

  assign go       = enable & key_complete & (inflight_q < IF_MAX);
  assign start_ok = idft_next_out & ~act_q & (inflight_q != '0);
  assign eof_set  = act_q & (ocnt_q == OC_LAST);
  assign buf_wr   = (state_q == S_FILL) & in_valid;
  assign buf_rd   = (state_q == S_STREAM);

  idft_seq_buffer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_fire),
    .wr_en_i  (buf_wr),
    .wr_data_i(in_data),
    .rd_en_i  (buf_rd),
    .rd_data_o(buf_rd_data),
    .wr_last_o(buf_wr_last),
    .rd_last_o(buf_rd_last)
  );

  // The last input beat can launch the frame directly, giving one cycle from final accept to next.
  always_comb begin
    state_d = state_q;
    next_d  = 1'b0;
    x_d     = '0;
    case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        if (in_valid && buf_wr_last) begin
          if (go) begin
            state_d = S_STREAM;
            next_d  = 1'b1;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (go) begin
          state_d = S_STREAM;
          next_d  = 1'b1;
        end
      end
      S_STREAM: begin
        x_d = buf_rd_data;
        if (buf_rd_last) state_d = S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
    if (wd_fire) begin
      state_d = S_FILL;
      next_d  = 1'b0;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (wd_fire) inflight_d = '0;
    else if (next_q && !eof_set) inflight_d = inflight_q + 1'b1;
    else if (!next_q && eof_set) inflight_d = inflight_q - 1'b1;
    started_d = started_q + 32'(next_q);
    done_d    = done_q + 32'(eof_set);
  end

  // Output framing: idft_y is registered once, so beats appear two cycles after next_out.
  always_comb begin
    act_d   = act_q;
    ocnt_d  = ocnt_q;
    ovld_d  = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    odata_d = '0;
    if (act_q) begin
      ovld_d  = 1'b1;
      odata_d = idft_y;
      sof_d   = (ocnt_q == '0);
      eof_d   = eof_set;
      ocnt_d  = eof_set ? '0 : ocnt_q + 1'b1;
      if (eof_set) act_d = 1'b0;
    end else if (start_ok) begin
      act_d  = 1'b1;
      ocnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      next_q     <= 1'b0;
      inflight_q <= '0;
      started_q  <= '0;
      done_q     <= '0;
      act_q      <= 1'b0;
      ocnt_q     <= '0;
      ovld_q     <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_q     <= next_d;
      inflight_q <= inflight_d;
      started_q  <= started_d;
      done_q     <= done_d;
      act_q      <= act_d;
      ocnt_q     <= ocnt_d;
      ovld_q     <= ovld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      odata_q <= '0;
    end else begin
      x_q     <= x_d;
      odata_q <= odata_d;
    end
  end

`ifdef IDFT_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           wd_run;

  // Runs while some started frame has not yet seen its next_out.
  assign wd_run  = inflight_q > IFW'(act_q);
  assign wd_fire = wd_run & ~start_ok & (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d  = '0;
    err_d = err_q | wd_fire;
    if (wd_fire || start_ok) wd_d = '0;
    else if (next_q && !wd_run) wd_d = WDW'(1);
    else if (wd_run) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign wd_fire        = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  assign in_ready       = (state_q == S_FILL);
  assign idft_next      = next_q;
  assign idft_x         = x_q;
  assign out_valid      = ovld_q;
  assign out_data       = odata_q;
  assign out_sof        = sof_q;
  assign out_eof        = eof_q;
  assign busy           = (state_q != S_IDLE) | (inflight_q != '0);
  assign frames_started = started_q;
  assign frames_done    = done_q;

endmodule

// File: tb/tb_idft_frame_sequencer.sv
// Self-checking bench for idft_frame_sequencer: randomized frames against a queue-based frame model.
module tb_idft_frame_sequencer;

  localparam int FC   = 32;
  localparam int MAXI = 2;
  localparam int TMO  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        key_complete = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        idft_next_out = 1'b0;
  logic [63:0] idft_y = '0;
  logic        in_ready, idft_next, out_valid, out_sof, out_eof, busy, err_timeout;
  logic [63:0] idft_x, out_data;
  logic [31:0] frames_started, frames_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_core_t = 0;

  logic [63:0] exp_x[$], got_x[$], exp_y[$], got_y[$];
  bit          got_sof[$], got_eof[$];
  int          nxt_times[$], sof_cyc[$], eof_cyc[$];
  int          str_left = 0;
  int          gap_err = 0;
  int          dbl_err = 0;
  bit          prev_next = 0;

  idft_frame_sequencer #(
    .FRAME_CYCLES(FC), .MAX_INFLIGHT(MAXI), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .key_complete(key_complete),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .idft_next(idft_next), .idft_x(idft_x),
    .idft_next_out(idft_next_out), .idft_y(idft_y),
    .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .busy(busy), .frames_started(frames_started), .frames_done(frames_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive observer: collects the streamed frame after every next pulse and every output beat.
  always @(negedge clk) begin
    if (rst) begin
      str_left  = 0;
      prev_next = 0;
    end else begin
      if (str_left > 0) begin
        got_x.push_back(idft_x);
        str_left--;
      end else if (idft_x !== 64'd0) begin
        gap_err++;
      end
      if (idft_next) begin
        nxt_times.push_back(cyc);
        str_left = FC;
        if (prev_next) dbl_err++;
      end
      prev_next = idft_next;
      if (out_valid) begin
        got_y.push_back(out_data);
        got_sof.push_back(out_sof);
        got_eof.push_back(out_eof);
        if (out_sof) sof_cyc.push_back(cyc);
        if (out_eof) eof_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench stopped");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_x.delete(); got_x.delete(); exp_y.delete(); got_y.delete();
    got_sof.delete(); got_eof.delete();
  endtask

  task automatic feed_frame(input bit ramp, input int gap_pct);
    int n = 0;
    int guard = 0;
    while (n < FC && guard < 2000) begin
      in_valid = ($urandom_range(99) >= 32'(gap_pct));
      in_data  = ramp ? {4{16'(n)}} : {$urandom, $urandom};
      if (in_valid && in_ready) begin
        exp_x.push_back(in_data);
        n++;
      end
      tick();
      guard++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    vectors++;
    if (n != FC) begin
      miscompares++;
      $display("FAIL feed_accept: accepted %0d beats, wanted %0d", n, FC);
    end
  endtask

  task automatic core_frame(input bit expect_out);
    idft_next_out = 1'b1;
    last_core_t   = cyc;
    tick();
    idft_next_out = 1'b0;
    for (int k = 0; k < FC; k++) begin
      idft_y = {$urandom, $urandom};
      if (expect_out) exp_y.push_back(idft_y);
      tick();
    end
    idft_y = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({in_ready, idft_next, out_valid, out_sof, out_eof, busy, err_timeout} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {in_ready, idft_next, out_valid, out_sof, out_eof, busy, err_timeout});
    end
    vectors++;
    if ({frames_started, frames_done} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d required 0/0", frames_started, frames_done);
    end
    vectors++;
    if ({idft_x, out_data} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h %h required 0", idft_x, out_data);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({in_ready, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL fill_entry: in_ready/busy got %b required 11", {in_ready, busy});
    end
  endtask

  task automatic test_spurious_next_out();
    int y0 = got_y.size();
    core_frame(1'b0);
    repeat (3) tick();
    vectors++;
    if (got_y.size() != y0 || frames_done !== 32'd0) begin
      miscompares++;
      $display("FAIL spurious_next_out: beats %0d done %0d required 0 0", got_y.size() - y0, frames_done);
    end
  endtask

  task automatic test_single_frame();
    int e0;
    enable = 1'b1;
    key_complete = 1'b1;
    clear_model();
    e0 = eof_cyc.size();
    feed_frame(1'b1, 0);
    vectors++;
    if ({in_ready, idft_next} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_handoff: in_ready/next got %b required 01", {in_ready, idft_next});
    end
    tick();
    vectors++;
    if (idft_next !== 1'b0 || frames_started !== 32'd1) begin
      miscompares++;
      $display("FAIL single_next_width: next %b started %0d required 0 1", idft_next, frames_started);
    end
    repeat (FC + 2) tick();
    vectors++;
    if (got_x.size() != FC || gap_err != 0 || dbl_err != 0) begin
      miscompares++;
      $display("FAIL single_stream: beats %0d gaps %0d dbl %0d required %0d 0 0", got_x.size(), gap_err, dbl_err, FC);
    end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      vectors++;
      if (got_x[i] !== exp_x[i]) begin
        miscompares++;
        $display("FAIL single_x[%0d]: got %h required %h", i, got_x[i], exp_x[i]);
      end
    end
    core_frame(1'b1);
    repeat (3) tick();
    vectors++;
    if (got_y.size() != FC || eof_cyc.size() != e0 + 1 || sof_cyc[$] != last_core_t + 2 || frames_done !== 32'd1) begin
      miscompares++;
      $display("FAIL single_out_frame: beats %0d sof_t %0d done %0d required %0d %0d 1",
               got_y.size(), sof_cyc[$], frames_done, FC, last_core_t + 2);
    end
    for (int i = 0; i < exp_y.size() && i < got_y.size(); i++) begin
      vectors++;
      if ({got_sof[i], got_eof[i], got_y[i]} !== {i == 0, i == FC - 1, exp_y[i]}) begin
        miscompares++;
        $display("FAIL single_y[%0d]: got %b%b %h required %b%b %h", i, got_sof[i], got_eof[i], got_y[i],
                 i == 0, i == FC - 1, exp_y[i]);
      end
    end
  endtask

  task automatic test_key_gate();
    int n0 = nxt_times.size();
    int d0 = frames_done;
    clear_model();
    key_complete = 1'b0;
    feed_frame(1'b0, 30);
    repeat (100) tick();
    vectors++;
    if (nxt_times.size() != n0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL key_gate_hold: nexts %0d in_ready %b required 0 0", nxt_times.size() - n0, in_ready);
    end
    key_complete = 1'b1;
    tick();
    vectors++;
    if (idft_next !== 1'b1) begin
      miscompares++;
      $display("FAIL key_gate_release: next got %b required 1", idft_next);
    end
    key_complete = 1'b0;
    enable = 1'b0;
    repeat (FC + 2) tick();
    enable = 1'b1;
    key_complete = 1'b1;
    vectors++;
    if (got_x.size() != FC) begin
      miscompares++;
      $display("FAIL key_stream_len: got %0d required %0d", got_x.size(), FC);
    end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      vectors++;
      if (got_x[i] !== exp_x[i]) begin
        miscompares++;
        $display("FAIL key_x[%0d]: got %h required %h", i, got_x[i], exp_x[i]);
      end
    end
    core_frame(1'b1);
    repeat (3) tick();
    vectors++;
    if (frames_done !== 32'(d0 + 1) || got_y.size() != FC) begin
      miscompares++;
      $display("FAIL key_out: done %0d beats %0d required %0d %0d", frames_done, got_y.size(), d0 + 1, FC);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = nxt_times.size();
    int e0 = eof_cyc.size();
    int s0 = frames_started;
    int d0 = frames_done;
    clear_model();
    for (int f = 0; f < 3; f++) feed_frame(1'b0, 0);
    repeat (20) tick();
    vectors++;
    if (nxt_times.size() - n0 != MAXI || frames_started !== 32'(s0 + MAXI)) begin
      miscompares++;
      $display("FAIL b2b_hold: nexts %0d started %0d required %0d %0d", nxt_times.size() - n0,
               frames_started, MAXI, s0 + MAXI);
    end
    core_frame(1'b1);
    repeat (5) tick();
    vectors++;
    if (nxt_times.size() - n0 != 3 || eof_cyc.size() != e0 + 1) begin
      miscompares++;
      $display("FAIL b2b_third_next: nexts %0d eofs %0d required 3 1", nxt_times.size() - n0, eof_cyc.size() - e0);
    end else begin
      vectors++;
      if (nxt_times[n0 + 2] < eof_cyc[e0] || nxt_times[n0 + 2] > eof_cyc[e0] + 3) begin
        miscompares++;
        $display("FAIL b2b_next_after_eof: next at %0d, eof at %0d", nxt_times[n0 + 2], eof_cyc[e0]);
      end
    end
    vectors++;
    if (frames_started !== 32'(s0 + 3)) begin
      miscompares++;
      $display("FAIL b2b_started: got %0d required %0d", frames_started, s0 + 3);
    end
    repeat (FC + 2) tick();
    core_frame(1'b1);
    repeat (4) tick();
    core_frame(1'b1);
    repeat (4) tick();
    vectors++;
    if (got_x.size() != 3 * FC || got_y.size() != 3 * FC || frames_done !== 32'(d0 + 3) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_totals: x %0d y %0d done %0d busy %b required %0d %0d %0d 1",
               got_x.size(), got_y.size(), frames_done, busy, 3 * FC, 3 * FC, d0 + 3);
    end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      vectors++;
      if (got_x[i] !== exp_x[i]) begin
        miscompares++;
        $display("FAIL b2b_x[%0d]: got %h required %h", i, got_x[i], exp_x[i]);
      end
    end
    for (int i = 0; i < exp_y.size() && i < got_y.size(); i++) begin
      vectors++;
      if ({got_sof[i], got_eof[i], got_y[i]} !== {(i % FC) == 0, (i % FC) == FC - 1, exp_y[i]}) begin
        miscompares++;
        $display("FAIL b2b_y[%0d]: got %b%b %h required %b%b %h", i, got_sof[i], got_eof[i], got_y[i],
                 (i % FC) == 0, (i % FC) == FC - 1, exp_y[i]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    clear_model();
    feed_frame(1'b0, 0);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    clear_model();
    vectors++;
    if ({in_ready, idft_next, out_valid, out_sof, out_eof, busy, err_timeout} !== 7'd0 ||
        {idft_x, out_data, frames_started, frames_done} !== 192'd0) begin
      miscompares++;
      $display("FAIL mid_reset: ctrl %b x %h started %0d done %0d required all 0",
               {in_ready, idft_next, out_valid, out_sof, out_eof, busy, err_timeout}, idft_x,
               frames_started, frames_done);
    end
    rst = 1'b0;
    tick();
    feed_frame(1'b1, 20);
    repeat (FC + 3) tick();
    vectors++;
    if (got_x.size() != FC || frames_started !== 32'd1) begin
      miscompares++;
      $display("FAIL post_reset_stream: beats %0d started %0d required %0d 1", got_x.size(), frames_started, FC);
    end
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++) begin
      vectors++;
      if (got_x[i] !== exp_x[i]) begin
        miscompares++;
        $display("FAIL post_reset_x[%0d]: got %h required %h", i, got_x[i], exp_x[i]);
      end
    end
    core_frame(1'b1);
    repeat (3) tick();
    vectors++;
    if (got_y.size() != FC || frames_done !== 32'd1) begin
      miscompares++;
      $display("FAIL post_reset_out: beats %0d done %0d required %0d 1", got_y.size(), frames_done, FC);
    end
    for (int i = 0; i < exp_y.size() && i < got_y.size(); i++) begin
      vectors++;
      if (got_y[i] !== exp_y[i]) begin
        miscompares++;
        $display("FAIL post_reset_y[%0d]: got %h required %h", i, got_y[i], exp_y[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    int y0;
    int d0 = frames_done;
    clear_model();
    feed_frame(1'b0, 0);
`ifdef IDFT_SEQ_WATCHDOG_EN
    repeat (TMO - 1) tick();
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_early: err got %b required 0", err_timeout);
    end
    tick();
    vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_fire: err got %b required 1", err_timeout);
    end
    repeat (20) tick();
    y0 = got_y.size();
    core_frame(1'b0);
    repeat (3) tick();
    vectors++;
    if (err_timeout !== 1'b1 || got_y.size() != y0 || in_ready !== 1'b1 || frames_done !== 32'(d0)) begin
      miscompares++;
      $display("FAIL wd_after: err %b beats %0d in_ready %b done %0d required 1 0 1 %0d",
               err_timeout, got_y.size() - y0, in_ready, frames_done, d0);
    end
`else
    repeat (TMO + 20) tick();
    vectors++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL no_wd_err: err %b busy %b required 0 1", err_timeout, busy);
    end
    y0 = got_y.size();
    core_frame(1'b1);
    repeat (3) tick();
    vectors++;
    if (got_y.size() - y0 != FC || frames_done !== 32'(d0 + 1) || err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL no_wd_drain: beats %0d done %0d err %b required %0d %0d 0",
               got_y.size() - y0, frames_done, err_timeout, FC, d0 + 1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_spurious_next_out();
    test_single_frame();
    test_key_gate();
    test_back_to_back();
    test_reset_mid_stream();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
